uart_cal_ctrl: RTL and testbench

Command sequencer for the UART calculator. Takes received bytes from the UART receiver, parses the ASCII expression "<A><op><B>=", and computes the result. It converts the result to decimal ASCII and drives the UART transmitter one byte at a time through a start/busy handshake. It is the only block that schedules the shared transmitter.

---
 rtl/uart_cal_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_uart_cal_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cal_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cal_ctrl
// Command sequencer for the UART calculator. Parses "<A><op><B>=" from the
// receiver byte stream, evaluates the expression, converts the result to
// decimal ASCII and feeds the shared transmitter one byte at a time.
//
// Ports:
//   clk        system clock
//   n_rst      synchronous active-low reset
//   rx_data    received byte
//   rx_valid   receiver byte-valid level (a byte is taken on its rising edge)
//   tx_busy    transmitter busy
//   tx_data    byte to transmit, held from tx_start until the next tx_start
//   tx_start   one-cycle transmit request
//   cal_busy   high whenever the parser is not collecting operands
//   err_pulse  one-cycle pulse when the "E\r\n" response is scheduled
//
// Optional feature macro: UART_CAL_DIV_EN
//   defined   -> '/' is accepted, quotient by repeated subtraction,
//                divide-by-zero answers "E\r\n"
//   undefined -> '/' is an illegal operator, no divider logic
// ---------------------------------------------------------------------------
module uart_cal_ctrl #(
    parameter int MAX_DIG = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       cal_busy,
    output logic       err_pulse
);

    localparam int CW = $clog2(MAX_DIG + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIG);

    typedef enum logic [2:0] {S_OPA, S_OPB, S_CALC, S_CONV, S_SEND, S_TXW, S_ERR} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

    state_e          state_q, state_d;
    op_e             op_q, op_d, op_dec;
    logic [6:0]      a_q, a_d, b_q, b_d;
    logic [CW-1:0]   a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic            rxv_q;
    logic            sign_q, sign_d;
    logic [13:0]     mag_q, mag_d;
    logic [1:0]      stage_q, stage_d;
    logic [3:0]      thou_q, thou_d, hund_q, hund_d, tens_q, tens_d;
    logic [7:0]      txbuf_q [8];
    logic [7:0]      txbuf_d [8];
    logic [2:0]      last_q, last_d, idx_q, idx_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d, start_dly_q;
    logic            err_q, err_d;

    logic            accept, is_digit, is_space, is_term, op_ok;
    logic [3:0]      digit;
    logic [13:0]     weight;

    assign accept   = rx_valid & ~rxv_q;
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_space = (rx_data == 8'h20);
    assign is_term  = (rx_data == 8'h3D) || (rx_data == 8'h0D);
    assign digit    = rx_data[3:0];

    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign err_pulse = err_q;
    assign cal_busy  = !((state_q == S_OPA) || (state_q == S_OPB));

    // Operator decode; '/' only exists when the divider is built in.
    always_comb begin
        op_ok  = 1'b1;
        op_dec = OP_ADD;
        case (rx_data)
            8'h2B:   op_dec = OP_ADD;
            8'h2D:   op_dec = OP_SUB;
            8'h2A:   op_dec = OP_MUL;
`ifdef UART_CAL_DIV_EN
            8'h2F:   op_dec = OP_DIV;
`endif
            default: op_ok = 1'b0;
        endcase
    end

    // Decimal weight of the digit currently being extracted in CONV.
    always_comb begin
        case (stage_q)
            2'd0:    weight = 14'd1000;
            2'd1:    weight = 14'd100;
            default: weight = 14'd10;
        endcase
    end

    // Next-state logic: parser, evaluator, BCD conversion and TX scheduler.
    always_comb begin : p_next
        logic [3:0] dv [4];
        logic [2:0] pos;
        logic       lead;

        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        a_cnt_d    = a_cnt_q;
        b_cnt_d    = b_cnt_q;
        sign_d     = sign_q;
        mag_d      = mag_q;
        stage_d    = stage_q;
        thou_d     = thou_q;
        hund_d     = hund_q;
        tens_d     = tens_q;
        txbuf_d    = txbuf_q;
        last_d     = last_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        err_d      = 1'b0;
        dv         = '{default: 4'd0};
        pos        = 3'd0;
        lead       = 1'b1;

        case (state_q)
            S_OPA: begin
                if (accept && !is_space) begin
                    if (is_digit && (a_cnt_q != MAX_CNT)) begin
                        a_d     = a_q * 7'd10 + {3'b000, digit};
                        a_cnt_d = a_cnt_q + 1'b1;
                    end else if (op_ok && (a_cnt_q != '0)) begin
                        op_d    = op_dec;
                        state_d = S_OPB;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end

            S_OPB: begin
                if (accept && !is_space) begin
                    if (is_digit && (b_cnt_q != MAX_CNT)) begin
                        b_d     = b_q * 7'd10 + {3'b000, digit};
                        b_cnt_d = b_cnt_q + 1'b1;
                    end else if (is_term && (b_cnt_q != '0)) begin
                        // mag doubles as the quotient accumulator for '/'.
                        mag_d   = '0;
                        sign_d  = 1'b0;
                        state_d = S_CALC;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end

            S_CALC: begin
                stage_d = 2'd0;
                thou_d  = 4'd0;
                hund_d  = 4'd0;
                tens_d  = 4'd0;
                state_d = S_CONV;
                case (op_q)
                    OP_ADD: mag_d = {7'd0, a_q} + {7'd0, b_q};
                    OP_SUB: begin
                        if (b_q > a_q) begin
                            sign_d = 1'b1;
                            mag_d  = {7'd0, b_q - a_q};
                        end else begin
                            mag_d  = {7'd0, a_q - b_q};
                        end
                    end
                    OP_MUL: mag_d = {7'd0, a_q} * {7'd0, b_q};
                    default: begin
`ifdef UART_CAL_DIV_EN
                        // A is consumed as the running remainder.
                        if (b_q == 7'd0) begin
                            txbuf_d[0] = 8'h45;
                            txbuf_d[1] = 8'h0D;
                            txbuf_d[2] = 8'h0A;
                            last_d     = 3'd2;
                            idx_d      = 3'd0;
                            err_d      = 1'b1;
                            state_d    = S_SEND;
                        end else if (a_q >= b_q) begin
                            a_d     = a_q - b_q;
                            mag_d   = mag_q + 14'd1;
                            state_d = S_CALC;
                        end
`else
                        mag_d = '0;
`endif
                    end
                endcase
            end

            S_CONV: begin
                if (mag_q >= weight) begin
                    mag_d = mag_q - weight;
                    case (stage_q)
                        2'd0:    thou_d = thou_q + 4'd1;
                        2'd1:    hund_d = hund_q + 4'd1;
                        default: tens_d = tens_q + 4'd1;
                    endcase
                end
                // Advance in the same cycle as the last subtraction so each
                // decade costs max(digit,1) cycles.
                if (mag_d < weight) begin
                    if (stage_q == 2'd2) begin
                        dv[0] = thou_d;
                        dv[1] = hund_d;
                        dv[2] = tens_d;
                        dv[3] = mag_d[3:0];
                        if (sign_q) begin
                            txbuf_d[0] = 8'h2D;
                            pos        = 3'd1;
                        end
                        for (int i = 0; i < 4; i++) begin
                            if ((dv[i] != 4'd0) || (i == 3) || !lead) begin
                                txbuf_d[pos] = {4'h3, dv[i]};
                                pos          = pos + 3'd1;
                                lead         = 1'b0;
                            end
                        end
                        txbuf_d[pos]        = 8'h0D;
                        txbuf_d[pos + 3'd1] = 8'h0A;
                        last_d              = pos + 3'd1;
                        idx_d               = 3'd0;
                        state_d             = S_SEND;
                    end else begin
                        stage_d = stage_q + 2'd1;
                    end
                end
            end

            S_SEND: begin
                if (!tx_busy) begin
                    tx_data_d  = txbuf_q[idx_q];
                    tx_start_d = 1'b1;
                    state_d    = S_TXW;
                end
            end

            S_TXW: begin
                // tx_busy is not trusted during the pulse cycle and the one
                // after it, while the transmitter is still picking up the start.
                if (!tx_start_q && !start_dly_q && !tx_busy) begin
                    if (idx_q == last_q) begin
                        a_d     = '0;
                        b_d     = '0;
                        a_cnt_d = '0;
                        b_cnt_d = '0;
                        state_d = S_OPA;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_SEND;
                    end
                end
            end

            S_ERR: begin
                if (accept && is_term) begin
                    txbuf_d[0] = 8'h45;
                    txbuf_d[1] = 8'h0D;
                    txbuf_d[2] = 8'h0A;
                    last_d     = 3'd2;
                    idx_d      = 3'd0;
                    err_d      = 1'b1;
                    state_d    = S_SEND;
                end
            end

            default: state_d = S_OPA;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= S_OPA;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
            rxv_q       <= 1'b0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            stage_q     <= '0;
            thou_q      <= '0;
            hund_q      <= '0;
            tens_q      <= '0;
            for (int i = 0; i < 8; i++) txbuf_q[i] <= '0;
            last_q      <= '0;
            idx_q       <= '0;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            start_dly_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            a_cnt_q     <= a_cnt_d;
            b_cnt_q     <= b_cnt_d;
            rxv_q       <= rx_valid;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            stage_q     <= stage_d;
            thou_q      <= thou_d;
            hund_q      <= hund_d;
            tens_q      <= tens_d;
            txbuf_q     <= txbuf_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            start_dly_q <= tx_start_q;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_cal_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_cal_ctrl
// Self-checking bench for uart_cal_ctrl. A simple transmitter model raises
// tx_busy for busy_len cycles after each tx_start; every transmitted byte is
// captured and compared with the decimal rendering of the expression result.
// Division scenarios follow the UART_CAL_DIV_EN macro.
// ---------------------------------------------------------------------------
module tb_uart_cal_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       cal_busy;
    logic       err_pulse;

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int busy_cnt = 0;
    int busy_len = 10;
    bit force_busy = 1'b0;
    int last_set_cyc = 0;

    byte unsigned txq[$];
    int           start_cyc[$];
    int           err_cnt = 0;
    int           busy_viol = 0;
    int           consec_viol = 0;
    bit           prev_start = 1'b0;

    uart_cal_ctrl dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .cal_busy  (cal_busy),
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for busy_len cycles after each start.
    always @(posedge clk) begin
        if (!n_rst)          busy_cnt <= 0;
        else if (tx_start)   busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || force_busy;

    // Capture transmitted bytes and handshake events between clock edges.
    always @(negedge clk) begin
        if (n_rst) begin
            if (tx_start) begin
                txq.push_back(tx_data);
                start_cyc.push_back(cyc);
                if (tx_busy) busy_viol++;
                if (prev_start) consec_viol++;
            end
            if (err_pulse) err_cnt++;
        end
        prev_start = tx_start;
    end

    // Reference: decimal text of the arithmetic result, or the error reply.
    function automatic string model(input int a, input int b, input byte op);
        int r;
        case (op)
            8'h2B:   r = a + b;
            8'h2D:   r = a - b;
            8'h2A:   r = a * b;
            default: begin
                if (b == 0) return $sformatf("E%c%c", 8'd13, 8'd10);
                r = a / b;
            end
        endcase
        if (r < 0) return $sformatf("-%0d%c%c", -r, 8'd13, 8'd10);
        return $sformatf("%0d%c%c", r, 8'd13, 8'd10);
    endfunction

    function automatic string err_resp();
        return $sformatf("E%c%c", 8'd13, 8'd10);
    endfunction

    function automatic string hexs(input string s);
        string h = "";
        for (int i = 0; i < s.len(); i++) h = {h, $sformatf("%02h ", s[i])};
        return h;
    endfunction

    function automatic string hexq();
        string h = "";
        for (int i = 0; i < txq.size(); i++) h = {h, $sformatf("%02h ", txq[i])};
        return h;
    endfunction

    task automatic send_byte(input byte unsigned b, input int hold);
        @(negedge clk);
        rx_data      = b;
        rx_valid     = 1'b1;
        last_set_cyc = cyc;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int hold);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], hold);
    endtask

    // Waits for the sequencer to go idle and returns the captured reply.
    task automatic collect(output string hx, output bit tmo);
        int n = 0;
        while (cal_busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        tmo = cal_busy;
        hx  = hexq();
        txq.delete();
    endtask

    task automatic wait_bytes(input int k, output bit tmo);
        int n = 0;
        while (txq.size() < k && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tmo = (txq.size() < k);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (tx_start !== 1'b0)   begin bad++; $display("[TB] FAIL reset_tx_start: got %b want 0", tx_start); end
        total++; if (cal_busy !== 1'b0)   begin bad++; $display("[TB] FAIL reset_cal_busy: got %b want 0", cal_busy); end
        total++; if (err_pulse !== 1'b0)  begin bad++; $display("[TB] FAIL reset_err_pulse: got %b want 0", err_pulse); end
        total++; if (tx_data !== 8'h00)   begin bad++; $display("[TB] FAIL reset_tx_data: got %02h want 00", tx_data); end
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        string hx; bit tmo; int e0;
        busy_len = 10;
        e0 = err_cnt;
        send_str("12+34=", 1);
        collect(hx, tmo);
        total++; if (tmo !== 1'b0) begin bad++; $display("[TB] FAIL basic_timeout: cal_busy stuck at 1"); end
        total++; if (hx != hexs(model(12, 34, 8'h2B))) begin bad++; $display("[TB] FAIL basic_resp: got %s want %s", hx, hexs(model(12, 34, 8'h2B))); end
        total++; if (err_cnt - e0 != 0) begin bad++; $display("[TB] FAIL basic_err: got %0d pulses want 0", err_cnt - e0); end
        total++; if (cal_busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_idle: got %b want 0", cal_busy); end
    endtask

    task automatic test_sub_zero();
        string hx; bit tmo;
        send_str("5-17=", 1);
        collect(hx, tmo);
        total++; if (hx != hexs(model(5, 17, 8'h2D))) begin bad++; $display("[TB] FAIL neg_resp: got %s want %s", hx, hexs(model(5, 17, 8'h2D))); end
        send_str("0*7=", 1);
        collect(hx, tmo);
        total++; if (hx != hexs(model(0, 7, 8'h2A))) begin bad++; $display("[TB] FAIL zero_resp: got %s want %s", hx, hexs(model(0, 7, 8'h2A))); end
    endtask

    task automatic test_long_hold();
        string hx; bit tmo; int lat;
        start_cyc.delete();
        send_str("99*99=", 16);
        lat = last_set_cyc;
        collect(hx, tmo);
        total++; if (hx != hexs(model(99, 99, 8'h2A))) begin bad++; $display("[TB] FAIL hold_resp: got %s want %s", hx, hexs(model(99, 99, 8'h2A))); end
        total++;
        if (start_cyc.size() == 0) begin
            bad++; $display("[TB] FAIL latency: got no tx_start want one within 30 cycles");
        end else if (start_cyc[0] - lat > 30) begin
            bad++; $display("[TB] FAIL latency: got %0d cycles want <= 30", start_cyc[0] - lat);
        end
    endtask

    task automatic test_errors();
        string cases [3];
        string hx; bit tmo; int e0;
        cases[0] = "1a2=";
        cases[1] = "123+1=";
        cases[2] = "+4=";
        for (int i = 0; i < 3; i++) begin
            e0 = err_cnt;
            send_str(cases[i], 1);
            collect(hx, tmo);
            total++; if (hx != hexs(err_resp())) begin bad++; $display("[TB] FAIL err_resp_%0d: got %s want %s", i, hx, hexs(err_resp())); end
            total++; if (err_cnt - e0 != 1) begin bad++; $display("[TB] FAIL err_pulse_%0d: got %0d pulses want 1", i, err_cnt - e0); end
        end
    endtask

    task automatic test_busy_hold();
        string hx; bit tmo; int n0;
        busy_len = 10;
        send_str("12*34=", 1);
        wait_bytes(1, tmo);
        @(negedge clk);
        force_busy = 1'b1;
        n0 = txq.size();
        repeat (200) @(negedge clk);
        total++; if (txq.size() != n0) begin bad++; $display("[TB] FAIL busy_hold_start: got %0d bytes want %0d", txq.size(), n0); end
        force_busy = 1'b0;
        collect(hx, tmo);
        total++; if (hx != hexs(model(12, 34, 8'h2A))) begin bad++; $display("[TB] FAIL busy_hold_resp: got %s want %s", hx, hexs(model(12, 34, 8'h2A))); end
    endtask

    task automatic test_drop();
        string hx; bit tmo;
        send_str("12+34=", 1);
        wait_bytes(1, tmo);
        send_str("3+3=", 1);
        collect(hx, tmo);
        total++; if (hx != hexs(model(12, 34, 8'h2B))) begin bad++; $display("[TB] FAIL drop_resp: got %s want %s", hx, hexs(model(12, 34, 8'h2B))); end
        send_str("1+1=", 1);
        collect(hx, tmo);
        total++; if (hx != hexs(model(1, 1, 8'h2B))) begin bad++; $display("[TB] FAIL drop_after: got %s want %s", hx, hexs(model(1, 1, 8'h2B))); end
    endtask

    task automatic test_reset_mid();
        string hx; bit tmo;
        send_str("99*99=", 1);
        wait_bytes(2, tmo);
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        total++; if (tx_start !== 1'b0) begin bad++; $display("[TB] FAIL midrst_tx_start: got %b want 0", tx_start); end
        total++; if (cal_busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_cal_busy: got %b want 0", cal_busy); end
        n_rst = 1'b1;
        txq.delete();
        @(negedge clk);
        send_str("2+2=", 1);
        collect(hx, tmo);
        total++; if (hx != hexs(model(2, 2, 8'h2B))) begin bad++; $display("[TB] FAIL midrst_resp: got %s want %s", hx, hexs(model(2, 2, 8'h2B))); end
    endtask

    task automatic test_divide();
        string hx; bit tmo; int e0;
`ifdef UART_CAL_DIV_EN
        send_str("99/7=", 1);
        collect(hx, tmo);
        total++; if (hx != hexs(model(99, 7, 8'h2F))) begin bad++; $display("[TB] FAIL div_resp: got %s want %s", hx, hexs(model(99, 7, 8'h2F))); end
        e0 = err_cnt;
        send_str("7/0=", 1);
        collect(hx, tmo);
        total++; if (hx != hexs(err_resp())) begin bad++; $display("[TB] FAIL div0_resp: got %s want %s", hx, hexs(err_resp())); end
        total++; if (err_cnt - e0 != 1) begin bad++; $display("[TB] FAIL div0_pulse: got %0d want 1", err_cnt - e0); end
`else
        e0 = err_cnt;
        send_str("8/2=", 1);
        collect(hx, tmo);
        total++; if (hx != hexs(err_resp())) begin bad++; $display("[TB] FAIL nodiv_resp: got %s want %s", hx, hexs(err_resp())); end
        total++; if (err_cnt - e0 != 1) begin bad++; $display("[TB] FAIL nodiv_pulse: got %0d want 1", err_cnt - e0); end
`endif
    endtask

    task automatic test_random();
        byte   ops [4];
        string s, hx, want;
        bit    tmo;
        int    a, b, nops, hold, e0, we;
        byte   op;
        ops[0] = 8'h2B; ops[1] = 8'h2D; ops[2] = 8'h2A; ops[3] = 8'h2F;
`ifdef UART_CAL_DIV_EN
        nops = 4;
`else
        nops = 3;
`endif
        for (int t = 0; t < 20; t++) begin
            a        = int'($urandom_range(0, 99));
            b        = int'($urandom_range(0, 99));
            if (t % 5 == 0) b = int'($urandom_range(0, 3));
            op       = ops[$urandom_range(0, nops - 1)];
            hold     = int'($urandom_range(1, 4));
            busy_len = int'($urandom_range(1, 12));
            s = (a < 10 && $urandom_range(0, 1) == 1) ? $sformatf("0%0d", a) : $sformatf("%0d", a);
            if ($urandom_range(0, 1) == 1) s = {s, " "};
            s = {s, $sformatf("%c", op)};
            s = {s, (b < 10 && $urandom_range(0, 1) == 1) ? $sformatf("0%0d", b) : $sformatf("%0d", b)};
            s = {s, ($urandom_range(0, 1) == 1) ? "=" : $sformatf("%c", 8'd13)};
            want = model(a, b, op);
            we   = (op == 8'h2F && b == 0) ? 1 : 0;
            e0   = err_cnt;
            send_str(s, hold);
            collect(hx, tmo);
            total++; if (hx != hexs(want)) begin bad++; $display("[TB] FAIL rand_%0d %0d%c%0d: got %s want %s", t, a, op, b, hx, hexs(want)); end
            total++; if (err_cnt - e0 != we) begin bad++; $display("[TB] FAIL rand_err_%0d: got %0d want %0d", t, err_cnt - e0, we); end
        end
        busy_len = 10;
    endtask

    task automatic test_handshake();
        total++; if (busy_viol != 0)   begin bad++; $display("[TB] FAIL start_while_busy: got %0d want 0", busy_viol); end
        total++; if (consec_viol != 0) begin bad++; $display("[TB] FAIL start_back_to_back: got %0d want 0", consec_viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sub_zero();
        test_long_hold();
        test_errors();
        test_busy_hold();
        test_drop();
        test_reset_mid();
        test_divide();
        test_random();
        test_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guards against a stuck run.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got no completion want $finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
